// File: rtl/digit_seq_pkg.sv
// Shared constants for the digit sequencer: direction encodings and default geometry/table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package digit_seq_pkg;

   // Direction encodings for the dir input
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Default geometry
   localparam int DEF_NUM_DIGITS = 9;
   localparam int DEF_DIGIT_W    = 4;
   localparam int DEF_IDX_W      = 4;

   // Reset contents of the digit table; digit i sits at [i*DIGIT_W +: DIGIT_W]
   localparam logic [DEF_NUM_DIGITS*DEF_DIGIT_W-1:0] DEF_TABLE = 36'h279580105;

endpackage

// File: rtl/digit_table.sv
// NUM_DIGITS x DIGIT_W register file, one sync write port, one async read port.
// Latency: write visible on read port the cycle after the write edge; read is combinational.
// Backpressure: none; writes to addresses >= NUM_DIGITS are dropped.
// Ports: i_clk/i_rst_n clock and async active-low reset (reloads DEFAULT_TABLE),
//        i_we/i_waddr/i_wdata write port, i_raddr/o_rdata read port.
module digit_table
   import digit_seq_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int DIGIT_W    = DEF_DIGIT_W,
   parameter int IDX_W      = DEF_IDX_W,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_TABLE = DEF_TABLE
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_we,
   input  logic [IDX_W-1:0]   i_waddr,
   input  logic [DIGIT_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]   i_raddr,
   output logic [DIGIT_W-1:0] o_rdata
);

   logic [DIGIT_W-1:0] r_mem [NUM_DIGITS];

   // Address decode by equality against each slot: out-of-range addresses match
   // no slot, so they are ignored on write and read back as zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_mem[i] <= DEFAULT_TABLE[i*DIGIT_W +: DIGIT_W];
         end
      end else if (i_we) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i_waddr == IDX_W'(i)) begin
               r_mem[i] <= i_wdata;
            end
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i_raddr == IDX_W'(i)) begin
            o_rdata = r_mem[i];
         end
      end
   end

endmodule

// File: rtl/digit_sequencer.sv
// Steps an index through NUM_DIGITS positions (up/down, wrap or saturate) and shows table[index].
// Latency: index moves on the edge that samples a step; digit_out follows combinationally.
// Backpressure: none; a step request is consumed every cycle it is presented.
// Ports: clk/reset (async active-low), advance/dir/wrap_en/clear step control,
//        load_en/load_addr/load_data table write, digit_out/current_state/at_last/wrap_pulse status.
module digit_sequencer
   import digit_seq_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int DIGIT_W    = DEF_DIGIT_W,
   parameter int IDX_W      = DEF_IDX_W,
   parameter bit EDGE_ADV   = 1'b0,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_TABLE = DEF_TABLE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               advance,
   input  logic               dir,
   input  logic               wrap_en,
   input  logic               clear,
   input  logic               load_en,
   input  logic [IDX_W-1:0]   load_addr,
   input  logic [DIGIT_W-1:0] load_data,
   output logic [DIGIT_W-1:0] digit_out,
   output logic [IDX_W-1:0]   current_state,
   output logic               at_last,
   output logic               wrap_pulse
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic             r_adv_q;
   logic [IDX_W-1:0] r_idx;
   logic             r_wrap_pulse;
   logic             w_step;
   logic             w_in_range;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_wrap;

   // In edge mode only the 0->1 transition of advance counts as a step.
   assign w_step     = EDGE_ADV ? (advance & ~r_adv_q) : advance;
   assign w_in_range = (r_idx <= LAST_IDX);

   always_comb begin
      w_idx_nxt = r_idx;
      w_wrap    = 1'b0;
      // An upset index outside the table is pulled back to 0, same as clear.
      if (clear || !w_in_range) begin
         w_idx_nxt = '0;
      end else if (w_step) begin
         if (dir == DIR_UP) begin
            if (r_idx != LAST_IDX) begin
               w_idx_nxt = r_idx + 1'b1;
            end else if (wrap_en) begin
               w_idx_nxt = '0;
               w_wrap    = 1'b1;
            end
         end else begin
            if (r_idx != '0) begin
               w_idx_nxt = r_idx - 1'b1;
            end else if (wrap_en) begin
               w_idx_nxt = LAST_IDX;
               w_wrap    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_adv_q      <= 1'b0;
         r_idx        <= '0;
         r_wrap_pulse <= 1'b0;
      end else begin
         r_adv_q      <= advance;
         r_idx        <= w_idx_nxt;
         r_wrap_pulse <= w_wrap;
      end
   end

   digit_table #(
      .NUM_DIGITS    (NUM_DIGITS),
      .DIGIT_W       (DIGIT_W),
      .IDX_W         (IDX_W),
      .DEFAULT_TABLE (DEFAULT_TABLE)
   ) u_table (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_we    (load_en),
      .i_waddr (load_addr),
      .i_wdata (load_data),
      .i_raddr (r_idx),
      .o_rdata (digit_out)
   );

   assign current_state = r_idx;
   assign at_last       = (r_idx == LAST_IDX);
   assign wrap_pulse    = r_wrap_pulse;

endmodule

// File: tb/tb_digit_sequencer.sv
module tb_digit_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       advance, dir, wrap_en, clear, load_en;
   logic [3:0] load_addr, load_data;

   logic [3:0] digit_l, state_l, digit_e, state_e;
   logic       last_l, wrap_l, last_e, wrap_e;

   always #5 clk = ~clk;

   digit_sequencer #(.NUM_DIGITS(9), .DIGIT_W(4), .IDX_W(4), .EDGE_ADV(1'b0),
                     .DEFAULT_TABLE(36'h279580105)) u_lvl (
      .clk(clk), .reset(reset), .advance(advance), .dir(dir), .wrap_en(wrap_en),
      .clear(clear), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .digit_out(digit_l), .current_state(state_l), .at_last(last_l), .wrap_pulse(wrap_l));

   digit_sequencer #(.NUM_DIGITS(9), .DIGIT_W(4), .IDX_W(4), .EDGE_ADV(1'b1),
                     .DEFAULT_TABLE(36'h279580105)) u_edg (
      .clk(clk), .reset(reset), .advance(advance), .dir(dir), .wrap_en(wrap_en),
      .clear(clear), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .digit_out(digit_e), .current_state(state_e), .at_last(last_e), .wrap_pulse(wrap_e));

   typedef struct packed {
      logic [3:0] dig;
      logic [3:0] st;
      logic       lst;
      logic       wr;
   } obs_t;

   obs_t q_lvl[$];
   obs_t q_edg[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain integers, index 0 = level DUT, 1 = edge DUT
   int         m_idx  [2];
   bit         m_advq [2];
   bit         m_wrap [2];
   logic [3:0] m_tbl  [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      logic [35:0] def;
      def = 36'h279580105;
      for (int i = 0; i < 9; i++) m_tbl[i] = def[i*4 +: 4];
      for (int e = 0; e < 2; e++) begin
         m_idx[e]  = 0;
         m_advq[e] = 1'b0;
         m_wrap[e] = 1'b0;
      end
   endtask

   task automatic model_step(input bit a, input bit d, input bit w, input bit c,
                             input bit le, input int la, input logic [3:0] ld);
      bit   stp;
      obs_t o;
      for (int e = 0; e < 2; e++) begin
         stp       = (e == 1) ? (a && !m_advq[e]) : a;
         m_advq[e] = a;
         m_wrap[e] = 1'b0;
         if (c) begin
            m_idx[e] = 0;
         end else if (stp) begin
            if (!d) begin
               if (m_idx[e] < 8) m_idx[e] = m_idx[e] + 1;
               else if (w) begin m_idx[e] = 0; m_wrap[e] = 1'b1; end
            end else begin
               if (m_idx[e] > 0) m_idx[e] = m_idx[e] - 1;
               else if (w) begin m_idx[e] = 8; m_wrap[e] = 1'b1; end
            end
         end
      end
      if (le && la < 9) m_tbl[la] = ld;
      for (int e = 0; e < 2; e++) begin
         o.dig = m_tbl[m_idx[e]];
         o.st  = 4'(m_idx[e]);
         o.lst = (m_idx[e] == 8);
         o.wr  = m_wrap[e];
         if (e == 0) q_lvl.push_back(o);
         else        q_edg.push_back(o);
      end
   endtask

   // One clock of stimulus: drive at negedge, predict the post-edge outputs
   task automatic cycle(input bit a, input bit d, input bit w, input bit c,
                        input bit le = 1'b0, input int la = 0, input logic [3:0] ld = 4'h0);
      @(negedge clk);
      reset     = 1'b1;
      advance   = a;
      dir       = d;
      wrap_en   = w;
      clear     = c;
      load_en   = le;
      load_addr = 4'(la);
      load_data = ld;
      model_step(a, d, w, c, le, la, ld);
   endtask

   // Asynchronous reset between edges; outputs must reflect it immediately
   task automatic do_reset(input string tag);
      @(negedge clk);
      advance = 1'b0; clear = 1'b0; load_en = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk({tag, ".lvl.digit"}, digit_l, 4'h5);
      chk({tag, ".lvl.state"}, state_l, 4'd0);
      chk({tag, ".lvl.last"},  last_l,  1'b0);
      chk({tag, ".lvl.wrap"},  wrap_l,  1'b0);
      chk({tag, ".edg.digit"}, digit_e, 4'h5);
      chk({tag, ".edg.state"}, state_e, 4'd0);
      chk({tag, ".edg.wrap"},  wrap_e,  1'b0);
      model_reset();
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compares whatever the scoreboard expects for this edge
   initial begin
      obs_t o;
      forever begin
         @(posedge clk);
         #1;
         if (q_lvl.size() > 0) begin
            o = q_lvl.pop_front();
            chk("sb.lvl.digit", digit_l, o.dig);
            chk("sb.lvl.state", state_l, o.st);
            chk("sb.lvl.last",  last_l,  o.lst);
            chk("sb.lvl.wrap",  wrap_l,  o.wr);
         end
         if (q_edg.size() > 0) begin
            o = q_edg.pop_front();
            chk("sb.edg.digit", digit_e, o.dig);
            chk("sb.edg.state", state_e, o.st);
            chk("sb.edg.last",  last_e,  o.lst);
            chk("sb.edg.wrap",  wrap_e,  o.wr);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; advance = 1'b0; dir = 1'b0; wrap_en = 1'b0; clear = 1'b0;
      load_en = 1'b0; load_addr = 4'h0; load_data = 4'h0;
      model_reset();
      #1 reset = 1'b0;
      #2;
      chk("rst.lvl.digit", digit_l, 4'h5);
      chk("rst.lvl.state", state_l, 4'd0);
      chk("rst.lvl.last",  last_l,  1'b0);
      chk("rst.lvl.wrap",  wrap_l,  1'b0);

      // 1: level advance, wrap through the end
      for (int k = 0; k < 9; k++) cycle(1, 0, 1, 0);
      after_edge();
      chk("t1.state", state_l, 4'd0);
      chk("t1.digit", digit_l, 4'h5);
      chk("t1.wrap",  wrap_l,  1'b1);

      // 2: saturate at the top
      cycle(0, 0, 0, 1);
      for (int k = 0; k < 12; k++) cycle(1, 0, 0, 0);
      after_edge();
      chk("t2.state", state_l, 4'd8);
      chk("t2.last",  last_l,  1'b1);
      chk("t2.wrap",  wrap_l,  1'b0);

      // 3: step down from 0, with and without wrap
      cycle(0, 0, 0, 1);
      cycle(1, 1, 1, 0);
      after_edge();
      chk("t3.lvl.state", state_l, 4'd8);
      chk("t3.lvl.digit", digit_l, 4'h2);
      chk("t3.lvl.wrap",  wrap_l,  1'b1);
      chk("t3.edg.state", state_e, 4'd8);
      cycle(0, 1, 0, 1);
      cycle(1, 1, 0, 0);
      after_edge();
      chk("t3.sat.state", state_l, 4'd0);
      chk("t3.sat.wrap",  wrap_l,  1'b0);
      chk("t3.sat.edg",   state_e, 4'd0);

      // 4: edge mode counts rising edges only
      cycle(0, 0, 1, 1);
      for (int k = 0; k < 5; k++) cycle(1, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(1, 0, 1, 0);
      after_edge();
      chk("t4.edg.state", state_e, 4'd2);
      chk("t4.lvl.state", state_l, 4'd6);

      // 5: table load, out-of-range load, write+step, clear beats step
      cycle(0, 0, 1, 0, 1, 3, 4'hA);
      cycle(0, 0, 1, 1);
      for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0);
      after_edge();
      chk("t5.load.digit", digit_l, 4'hA);
      cycle(0, 0, 1, 0, 1, 9, 4'hF);
      cycle(1, 0, 1, 0, 1, 3, 4'h6);
      cycle(0, 1, 1, 0);
      cycle(1, 1, 1, 0);
      after_edge();
      chk("t5.wr_step.digit", digit_l, 4'h6);
      cycle(1, 0, 1, 1);
      after_edge();
      chk("t5.clear.state", state_l, 4'd0);

      // 6: reset mid-sequence drops loaded digits
      for (int k = 0; k < 5; k++) cycle(1, 0, 1, 0);
      after_edge();
      chk("t6.pre.state", state_l, 4'd5);
      do_reset("t6");
      for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0);
      after_edge();
      chk("t6.default.digit", digit_l, 4'h0);

      // Random traffic against the model, with one async reset in the middle
      for (int k = 0; k < 400; k++) begin
         if (k == 200) do_reset("rnd");
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
               int'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      cycle(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("sb.drained", q_lvl.size() + q_edg.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
